imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream (word count, instruction words, checksum) over a valid/ready handshake, packs bytes into `width`-bit instruction words and writes them to consecutive imem rows starting at row 0 through the imem write port (`cs`, `wen`, `address`, `d`). Holds the core in reset while loading and reports done or error.

## Interface
Parameters:
- `width`, 28, instruction word width; must be ≤ 32.
- `rows`, 2048, imem depth.
- `add_size`, 11, imem address width.

Ports:
- `clk`  in  1  clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a load; honoured only when `busy`=0.
- `rx_valid`  in  1  byte available.
- `rx_data`  in  8  byte payload.
- `rx_ready`  out  1  loader can accept a byte; transfer occurs when `rx_valid && rx_ready`.
- `cs`  out  1  imem chip select.
- `wen`  out  2  imem write enables; only `2'b00` or `2'b11` are driven.
- `address`  out  add_size  imem row.
- `d`  out  width  imem write data.
- `busy`  out  1  load in progress.
- `core_hold`  out  1  equals `busy`; keeps the core in reset.
- `done`  out  1  sticky: last load completed, checksum good.
- `err`  out  1  sticky: last load failed.

## Operation
- Stream format:
  - Byte 0: count[7:0]. Byte 1: count[15:8]. Together they give N, the number of words.
  - Then N words of 4 bytes each, little-endian. The word is `{b3,b2,b1,b0}[width-1:0]`; upper bits are discarded.
  - Last byte: checksum. It must equal the XOR of every preceding stream byte, count bytes included.
- FSM states: IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHK, DONE, ERR.
- IDLE/DONE/ERR, on `start`: go to CNT_LO; clear `done`/`err`; clear running XOR, address and byte index.
- CNT_LO: on accept, latch count low byte → CNT_HI.
- CNT_HI: on accept, latch count high byte.
  - N > `rows` → ERR.
  - N = 0 → CHK.
  - Otherwise → DATA.
- DATA: accept bytes into byte lane 0..3 (2-bit index). On the 4th byte → WRITE.
- WRITE: exactly one cycle with `cs`=1, `wen`=2'b11, `address`=current row, `d`=packed word. Then increment the row and the words-written count.
  - Words written = N → CHK.
  - Otherwise → DATA.
- CHK: on accept, compare the byte to the running XOR. Match → DONE (`done`=1). Mismatch → ERR (`err`=1).
- The running XOR updates on every accepted byte except the checksum byte.
- `rx_ready`=1 only in CNT_LO, CNT_HI, DATA and CHK. It is 0 in WRITE, IDLE, DONE and ERR.
- `busy`=1 in every state except IDLE, DONE and ERR.
- Bytes arriving while `rx_ready`=0 are not consumed.
- `start` while `busy`=1 is ignored.
- Address arithmetic is `add_size` bits. It never wraps, because N ≤ `rows` is enforced.
- Reset mid-load:
  - FSM returns to IDLE and all outputs are cleared.
  - Rows already written keep their contents; the loader does not clear the imem.

## Timing
- All outputs are registered.
- Reset values: `rx_ready`=0, `cs`=0, `wen`=0, `address`=0, `d`=0, `busy`=0, `core_hold`=0, `done`=0, `err`=0.
- `start` at cycle t → `busy`=1 and `rx_ready`=1 at t+1.
- The 4th byte of a word accepted at cycle t → write strobe (`cs`/`wen`) is visible at t+1 and `rx_ready`=1 again at t+2.
- Minimum of 5 cycles per word with `rx_valid` held high.
- Checksum byte accepted at cycle t → `done` or `err` is 1 at t+1 and `busy`=0 at t+1.
- Outside the WRITE state, `cs`=0 and `wen`=0. `address` and `d` hold their last values.

## Test plan
- N=2, words 0x0123456, 0xABCDEF0, correct checksum, `rx_valid` always high:
  - rows 0 and 1 are written with those values, exactly 2 write strobes;
  - `done`=1 and `err`=0;
  - `busy` high for 2+8+2+1 cycles.
- N=1, byte 3 = 0xF5: the written word is `{4'h5,b2,b1,b0}`, i.e. upper nibble discarded, with `width`=28.
- N=0 followed by checksum 0x00 → `done`=1 and no write strobe. Checksum 0x01 → `err`=1 and no write strobe.
- N=2049 (count bytes 0x01, 0x08) → `err`=1 right after CNT_HI, zero writes, `rx_ready`=0.
- Random `rx_valid` gaps, N=3, plus `start` pulses injected while busy → identical imem contents to the gap-free run, and the `start` pulses are ignored.
- `reset` asserted after 1.5 words of N=4 → all outputs are 0 next cycle and row 0 is already written. A new `start` then loads correctly from row 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a byte stream (count, words, checksum),
// packs bytes into instruction words, writes consecutive imem rows and holds the core in reset.
module imem_loader #(
    parameter int width    = 28,
    parameter int rows     = 2048,
    parameter int add_size = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic                cs,
    output logic [1:0]          wen,
    output logic [add_size-1:0] address,
    output logic [width-1:0]    d,
    output logic                busy,
    output logic                core_hold,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [add_size-1:0] row_one = add_size'(1);

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           wcnt_q, wcnt_d;
    logic [add_size-1:0]   row_q, row_d;
    logic [1:0]            lane_q, lane_d;
    logic [23:0]           word_q, word_d;
    logic [7:0]            xor_q, xor_d;

    logic                  rx_ready_q, rx_ready_d;
    logic                  cs_q, cs_d;
    logic [add_size-1:0]   address_q, address_d;
    logic [width-1:0]      d_q, d_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic [15:0]           n_words;

    assign accept  = rx_valid && rx_ready_q;
    assign n_words = {rx_data, cnt_q[7:0]};

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        row_d     = row_q;
        lane_d    = lane_q;
        word_d    = word_q;
        xor_d     = xor_q;
        address_d = address_q;
        d_d       = d_q;
        done_d    = done_q;
        err_d     = err_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d   = CNT_LO;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    xor_d     = 8'h00;
                    row_d     = '0;
                    lane_d    = 2'd0;
                    wcnt_d    = 16'd0;
                    address_d = '0;
                end
            end

            CNT_LO: begin
                if (accept) begin
                    cnt_d[7:0] = rx_data;
                    xor_d      = xor_q ^ rx_data;
                    state_d    = CNT_HI;
                end
            end

            CNT_HI: begin
                if (accept) begin
                    cnt_d = n_words;
                    xor_d = xor_q ^ rx_data;
                    // Oversized images are rejected before any row is touched.
                    if ({16'd0, n_words} > 32'(rows)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (n_words == 16'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    xor_d  = xor_q ^ rx_data;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        2'd3: begin
                            // Bits above the instruction width are dropped here.
                            d_d       = width'({rx_data, word_q});
                            address_d = row_q;
                            state_d   = WRITE;
                        end
                        default: ;
                    endcase
                end
            end

            WRITE: begin
                row_d  = row_q + row_one;
                wcnt_d = wcnt_q + 16'd1;
                if (wcnt_q + 16'd1 == cnt_q) begin
                    state_d = CHK;
                end else begin
                    state_d = DATA;
                end
            end

            CHK: begin
                if (accept) begin
                    if (rx_data == xor_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies of what the next state implies.
        rx_ready_d = (state_d == CNT_LO) || (state_d == CNT_HI) ||
                     (state_d == DATA)   || (state_d == CHK);
        busy_d     = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
        cs_d       = (state_d == WRITE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            wcnt_q     <= 16'd0;
            row_q      <= '0;
            lane_q     <= 2'd0;
            word_q     <= 24'd0;
            xor_q      <= 8'h00;
            rx_ready_q <= 1'b0;
            cs_q       <= 1'b0;
            address_q  <= '0;
            d_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            row_q      <= row_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            xor_q      <= xor_d;
            rx_ready_q <= rx_ready_d;
            cs_q       <= cs_d;
            address_q  <= address_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign cs        = cs_q;
    assign wen       = {2{cs_q}};
    assign address   = address_q;
    assign d         = d_q;
    assign busy      = busy_q;
    assign core_hold = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a monitor checks each strobe.
module tb_imem_loader;

    localparam int W    = 28;
    localparam int ROWS = 2048;
    localparam int AS   = 11;

    logic          clk;
    logic          reset;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          cs;
    logic [1:0]    wen;
    logic [AS-1:0] address;
    logic [W-1:0]  d;
    logic          busy;
    logic          core_hold;
    logic          done;
    logic          err;

    imem_loader #(.width(W), .rows(ROWS), .add_size(AS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .cs        (cs),
        .wen       (wen),
        .address   (address),
        .d         (d),
        .busy      (busy),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AS-1:0] a;
        logic [W-1:0]  d;
    } wr_t;

    wr_t          exp_q[$];
    logic [W-1:0] tb_mem [ROWS];
    logic [W-1:0] snap [3];
    int           checks    = 0;
    int           failures  = 0;
    int           strobes   = 0;
    int           busy_cycles = 0;
    logic [7:0]   tb_xor;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (busy !== core_hold) check("core_hold_eq_busy", 32'(core_hold), 32'(busy));
        if (cs) begin
            wr_t e;
            strobes++;
            tb_mem[address] = d;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(address), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(address), 32'(e.a));
                check("wr_data", 32'(d), 32'(e.d));
                check("wr_wen", 32'(wen), 32'd3);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
        bit ok;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            if (inj && i == 0) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        rx_valid = 1'b0;
        if (!ok) check("rx_timeout", 32'd0, 32'd1);
        tb_xor = tb_xor ^ b;
    endtask

    task automatic begin_load();
        tb_xor      = 8'h00;
        strobes     = 0;
        busy_cycles = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic send_cnt(input logic [15:0] n, input bit gaps);
        send_byte(n[7:0],  gaps ? int'($urandom_range(0, 3)) : 0, gaps);
        send_byte(n[15:8], gaps ? int'($urandom_range(0, 3)) : 0, gaps);
    endtask

    task automatic send_word(input logic [31:0] bytes, input logic [W-1:0] exp,
                             input logic [AS-1:0] row, input bit gaps);
        wr_t e;
        e.a = row;
        e.d = exp;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            send_byte(bytes[8*k +: 8], gaps ? int'($urandom_range(0, 3)) : 0, gaps);
        end
    endtask

    task automatic finish_load(input logic [7:0] chk, input bit exp_done,
                               input int exp_strobes, input int exp_busy);
        send_byte(chk, 0, 1'b0);
        check("end_done", 32'(done), 32'(exp_done));
        check("end_err", 32'(err), 32'(!exp_done));
        check("end_busy", 32'(busy), 32'd0);
        check("end_rx_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("strobe_count", 32'(strobes), 32'(exp_strobes));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        if (exp_busy >= 0) check("busy_cycles", 32'(busy_busy_guard(exp_busy)), 32'(exp_busy));
    endtask

    function automatic int busy_busy_guard(input int unused_exp);
        return busy_cycles + 0 * unused_exp;
    endfunction

    task automatic load3(input bit gaps);
        begin_load();
        send_cnt(16'd3, gaps);
        send_word(32'h12345678, 28'h2345678, 11'd0, gaps);
        send_word(32'hDEADBEEF, 28'hEADBEEF, 11'd1, gaps);
        send_word(32'h04030201, 28'h4030201, 11'd2, gaps);
        finish_load(tb_xor, 1'b1, 3, gaps ? -1 : 18);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({rx_ready, cs, wen, busy, core_hold, done, err}), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // N=2, gap-free, hand-computed checksum 0xEA.
        begin_load();
        send_cnt(16'd2, 1'b0);
        send_word(32'h00123456, 28'h0123456, 11'd0, 1'b0);
        send_word(32'h0ABCDEF0, 28'hABCDEF0, 11'd1, 1'b0);
        finish_load(8'hEA, 1'b1, 2, 13);
        check("row0", 32'(tb_mem[0]), 32'h0123456);
        check("row1", 32'(tb_mem[1]), 32'hABCDEF0);

        // N=1, upper nibble of byte 3 discarded.
        begin_load();
        send_cnt(16'd1, 1'b0);
        send_word(32'hF5332211, 28'h5332211, 11'd0, 1'b0);
        finish_load(tb_xor, 1'b1, 1, 8);

        // N=0 with good and bad checksums.
        begin_load();
        send_cnt(16'd0, 1'b0);
        finish_load(8'h00, 1'b1, 0, 3);
        begin_load();
        send_cnt(16'd0, 1'b0);
        finish_load(8'h01, 1'b0, 0, 3);

        // N=2049 rejected right after the count.
        begin_load();
        send_cnt(16'h0801, 1'b0);
        check("big_err", 32'(err), 32'd1);
        check("big_done", 32'(done), 32'd0);
        check("big_rx_ready", 32'(rx_ready), 32'd0);
        check("big_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("big_strobes", 32'(strobes), 32'd0);

        // N=3 gap-free, then with random gaps and stray start pulses.
        load3(1'b0);
        for (int r = 0; r < 3; r++) begin
            snap[r]   = tb_mem[r];
            tb_mem[r] = '0;
        end
        load3(1'b1);
        for (int r = 0; r < 3; r++) check("gap_vs_nogap", 32'(tb_mem[r]), 32'(snap[r]));

        // Reset after 1.5 words of N=4.
        tb_mem[0] = '0;
        begin_load();
        send_cnt(16'd4, 1'b0);
        send_word(32'hA1B2C3D4, 28'h1B2C3D4, 11'd0, 1'b0);
        send_byte(8'h77, 0, 1'b0);
        send_byte(8'h66, 0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ctrl", 32'({rx_ready, cs, wen, busy, core_hold, done, err}), 32'd0);
        check("midrst_addr", 32'(address), 32'd0);
        check("midrst_d", 32'(d), 32'd0);
        check("midrst_row0", 32'(tb_mem[0]), 32'h1B2C3D4);
        reset = 1'b0;
        @(posedge clk);
        #1;
        begin_load();
        send_cnt(16'd1, 1'b0);
        send_word(32'h0C0FFEE0, 28'hC0FFEE0, 11'd0, 1'b0);
        finish_load(tb_xor, 1'b1, 1, 8);
        check("reload_row0", 32'(tb_mem[0]), 32'hC0FFEE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
